// File: rtl/memory_arbiter_pkg.sv
// Shared operation codes, FSM state and grant encodings for the memory arbiter.
// The OP_* codes match those the 16x16 memory block decodes.
package memory_arbiter_pkg;

  localparam logic [2:0] OP_IDLE  = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_READ) || (op == OP_WRITE) || (op == OP_CLEAR);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the requester that was
// not granted last time wins. grant_b / last_grant_b: 0 = A, 1 = B.
module rr_arbiter2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant_b,
  output logic grant_valid,
  output logic grant_b
);

  always_comb begin
    grant_b = 1'b0;
    if (req_a && req_b) begin
      grant_b = ~last_grant_b;
    end else if (req_b) begin
      grant_b = 1'b1;
    end
  end

  assign grant_valid = req_a | req_b;

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter and sequencer for two clients sharing one memory.
// Optional ISSUE watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
import memory_arbiter_pkg::*;

module memory_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [2:0]        op_a,
  input  logic [2:0]        op_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              rsp_done_a,
  output logic              rsp_done_b,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [2:0]        mem_operation,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_done
);

  arb_state_t        state, state_n;
  grant_t            last_grant, last_grant_n;
  grant_t            owner, owner_n;
  logic              pick_valid, pick_b;
  grant_t            pick;
  logic [2:0]        pick_op;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic              timed_out;
  logic              enter_resp;

  logic [2:0]        mem_operation_n;
  logic [ADDR_W-1:0] mem_address_n;
  logic [DATA_W-1:0] mem_data_in_n;
  logic [DATA_W-1:0] rsp_rdata_n;
  logic              rsp_err_n;
  logic              rsp_done_a_n, rsp_done_b_n;

  rr_arbiter2 u_rr (
    .req_a        (req_a),
    .req_b        (req_b),
    .last_grant_b (last_grant == GRANT_B),
    .grant_valid  (pick_valid),
    .grant_b      (pick_b)
  );

  assign pick       = pick_b ? GRANT_B : GRANT_A;
  assign pick_op    = pick_b ? op_b    : op_a;
  assign pick_addr  = pick_b ? addr_b  : addr_a;
  assign pick_wdata = pick_b ? wdata_b : wdata_a;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;

  // Counts ISSUE cycles; it sits at zero everywhere else, so it starts cleared on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ARB_ISSUE) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign timed_out = (state == ARB_ISSUE) && (to_cnt == CNT_W'(TIMEOUT));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    // NOTE: every value this block writes gets a default first, so no latch is inferred.
    state_n         = state;
    last_grant_n    = last_grant;
    owner_n         = owner;
    mem_operation_n = mem_operation;
    mem_address_n   = mem_address;
    mem_data_in_n   = mem_data_in;
    rsp_rdata_n     = rsp_rdata;
    rsp_err_n       = rsp_err;
    enter_resp      = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_n      = pick;
          last_grant_n = pick;
          if (op_legal(pick_op)) begin
            state_n         = ARB_ISSUE;
            mem_operation_n = pick_op;
            mem_address_n   = pick_addr;
            mem_data_in_n   = pick_wdata;
          end else begin
            // Illegal op completes immediately; the memory never sees it.
            state_n     = ARB_RESP;
            enter_resp  = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
          end
        end
      end
      ARB_ISSUE: begin
        if (mem_done) begin
          state_n         = ARB_RESP;
          enter_resp      = 1'b1;
          mem_operation_n = OP_IDLE;
          rsp_err_n       = 1'b0;
          rsp_rdata_n     = (mem_operation == OP_READ) ? mem_data_out : '0;
        end else if (timed_out) begin
          state_n         = ARB_RESP;
          enter_resp      = 1'b1;
          mem_operation_n = OP_IDLE;
          rsp_err_n       = 1'b1;
          rsp_rdata_n     = '0;
        end
      end
      ARB_RESP: begin
        state_n = ARB_IDLE;
      end
      default: begin
        state_n         = ARB_IDLE;
        mem_operation_n = OP_IDLE;
      end
    endcase

    rsp_done_a_n = enter_resp && (owner_n == GRANT_A);
    rsp_done_b_n = enter_resp && (owner_n == GRANT_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ARB_IDLE;
      last_grant    <= GRANT_B;
      owner         <= GRANT_A;
      mem_operation <= OP_IDLE;
      mem_address   <= '0;
      mem_data_in   <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      rsp_done_a    <= 1'b0;
      rsp_done_b    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register updates together.
      state         <= state_n;
      last_grant    <= last_grant_n;
      owner         <= owner_n;
      mem_operation <= mem_operation_n;
      mem_address   <= mem_address_n;
      mem_data_in   <= mem_data_in_n;
      rsp_rdata     <= rsp_rdata_n;
      rsp_err       <= rsp_err_n;
      rsp_done_a    <= rsp_done_a_n;
      rsp_done_b    <= rsp_done_b_n;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter with a behavioural IDLE->DECODER->GET
// memory model and a scoreboard of expected completions.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_a = 1'b0, req_b = 1'b0;
  logic [2:0]        op_a = '0, op_b = '0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;
  logic              rsp_done_a, rsp_done_b, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [2:0]        mem_operation;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out = '0;
  logic              mem_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .rsp_done_a(rsp_done_a), .rsp_done_b(rsp_done_b),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_operation(mem_operation), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_done(mem_done)
  );

  // Memory model: leaves IDLE on a non-zero op, performs it entering GET, done while in GET.
  // It has no reset, so an arbiter reset can leave it parked in DECODER.
  typedef enum logic [1:0] {M_IDLE, M_DECODER, M_GET} mstate_t;
  mstate_t           mstate = M_IDLE;
  logic [DATA_W-1:0] marr [16];
  logic              mem_hold = 1'b0;

  initial for (int i = 0; i < 16; i++) marr[i] = '0;

  always @(posedge clk) begin
    case (mstate)
      M_IDLE: if (mem_operation != OP_IDLE) mstate <= M_DECODER;
      M_DECODER: if (mem_operation != OP_IDLE && !mem_hold) begin
        mstate <= M_GET;
        case (mem_operation)
          OP_READ:  mem_data_out <= marr[mem_address];
          OP_WRITE: marr[mem_address] <= mem_data_in;
          OP_CLEAR: marr[mem_address] <= '0;
          default: ;
        endcase
      end
      default: mstate <= M_IDLE;
    endcase
  end
  assign mem_done = (mstate == M_GET);

  // Scoreboard: expected completions in service order, plus a reference copy of memory.
  typedef struct {
    logic              who;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } exp_t;
  exp_t              sb[$];
  exp_t              got;
  logic [DATA_W-1:0] ref_mem [16];
  logic              tb_last = 1'b1;

  initial for (int i = 0; i < 16; i++) ref_mem[i] = '0;

  task automatic push_exp(input logic who, input logic [2:0] op,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    exp_t e;
    e.who   = who;
    e.err   = !(op == 3'd1 || op == 3'd2 || op == 3'd3);
    e.rdata = (op == 3'd1) ? ref_mem[addr] : '0;
    if (op == 3'd2) ref_mem[addr] = wdata;
    if (op == 3'd3) ref_mem[addr] = '0;
    tb_last = who;
    sb.push_back(e);
  endtask

  // Completion monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rsp_done_a || rsp_done_b) begin
      n_cmp++;
      if (rsp_done_a && rsp_done_b) begin
        n_bad++;
        $display("FAIL both_done: rsp_done_a=1 rsp_done_b=1, want exactly one");
      end else if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: done_a=%0b done_b=%0b with nothing outstanding",
                 rsp_done_a, rsp_done_b);
      end else begin
        got = sb.pop_front();
        if (rsp_done_b !== got.who || rsp_err !== got.err || rsp_rdata !== got.rdata) begin
          n_bad++;
          $display("FAIL completion: who=%0b err=%0b rdata=%h, want who=%0b err=%0b rdata=%h",
                   rsp_done_b, rsp_err, rsp_rdata, got.who, got.err, got.rdata);
        end
      end
      n_cmp++;
      if (mem_operation !== OP_IDLE) begin
        n_bad++;
        $display("FAIL resp_mem_op: mem_operation=%0d in RESP, want 0", mem_operation);
      end
    end
  end

  task automatic drive(input logic who, input logic [2:0] op,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    @(negedge clk);
    if (!who) begin
      req_a = 1'b1; op_a = op; addr_a = addr; wdata_a = wdata;
    end else begin
      req_b = 1'b1; op_b = op; addr_b = addr; wdata_b = wdata;
    end
  endtask

  task automatic release_req(input logic who);
    @(negedge clk);
    if (!who) req_a = 1'b0;
    else      req_b = 1'b0;
  endtask

  // k = index of the rising edge (0 = first after the call) after which done is seen; -1 if never.
  task automatic wait_done(input logic who, input int budget, output int k);
    k = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if ((!who && rsp_done_a) || (who && rsp_done_b)) begin
        k = i;
        return;
      end
    end
  endtask

  function automatic logic [41:0] outs();
    return {rsp_done_a, rsp_done_b, rsp_err, rsp_rdata, mem_operation, mem_address, mem_data_in};
  endfunction

  task automatic test_reset();
    #1;
    n_cmp++;
    if (outs() !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, want 0", outs());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tb_last = 1'b1;
  endtask

  task automatic test_write_read();
    int k;
    push_exp(1'b0, OP_WRITE, 4'd5, 16'hBEEF);
    drive(1'b0, OP_WRITE, 4'd5, 16'hBEEF);
    wait_done(1'b0, 20, k);
    n_cmp++;
    if (k !== 3) begin
      n_bad++;
      $display("FAIL write_latency: done at edge %0d, want 3", k);
    end
    release_req(1'b0);
    push_exp(1'b0, OP_READ, 4'd5, '0);
    drive(1'b0, OP_READ, 4'd5, '0);
    wait_done(1'b0, 20, k);
    n_cmp++;
    if (k !== 3) begin
      n_bad++;
      $display("FAIL read_latency: done at edge %0d, want 3", k);
    end
    release_req(1'b0);
  endtask

  task automatic test_round_robin();
    for (int r = 0; r < 4; r++) begin
      logic              w;
      int                k;
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] wd;
      wa = ADDR_W'(8 + r);
      wd = DATA_W'(16'h1111 * (r + 1));
      w  = ~tb_last;
      if (!w) begin
        push_exp(1'b0, OP_WRITE, wa, wd);
        push_exp(1'b1, OP_READ, 4'd5, '0);
      end else begin
        push_exp(1'b1, OP_READ, 4'd5, '0);
        push_exp(1'b0, OP_WRITE, wa, wd);
      end
      @(negedge clk);
      req_a = 1'b1; op_a = OP_WRITE; addr_a = wa;   wdata_a = wd;
      req_b = 1'b1; op_b = OP_READ;  addr_b = 4'd5; wdata_b = '0;
      wait_done(w, 20, k);
      n_cmp++;
      if (k !== 3) begin
        n_bad++;
        $display("FAIL rr_winner_latency round %0d: winner %0b done at edge %0d, want 3", r, w, k);
      end
      release_req(w);
      wait_done(~w, 20, k);
      n_cmp++;
      if (k !== 4) begin
        n_bad++;
        $display("FAIL rr_loser_latency round %0d: loser done at edge %0d, want 4", r, k);
      end
      release_req(~w);
    end
  endtask

  task automatic test_clear_read();
    int k;
    push_exp(1'b1, OP_CLEAR, 4'd5, '0);
    drive(1'b1, OP_CLEAR, 4'd5, 16'hFFFF);
    wait_done(1'b1, 20, k);
    n_cmp++;
    if (k !== 3) begin
      n_bad++;
      $display("FAIL clear_latency: done at edge %0d, want 3", k);
    end
    release_req(1'b1);
    push_exp(1'b1, OP_READ, 4'd5, '0);
    drive(1'b1, OP_READ, 4'd5, '0);
    wait_done(1'b1, 20, k);
    release_req(1'b1);
  endtask

  task automatic test_illegal();
    logic [2:0] ops [2];
    ops[0] = 3'd5;
    ops[1] = 3'd0;
    for (int t = 0; t < 2; t++) begin
      logic who;
      int   k;
      logic touched;
      who = (t == 1);
      touched = 1'b0;
      k = -1;
      push_exp(who, ops[t], 4'd2, 16'h1234);
      drive(who, ops[t], 4'd2, 16'h1234);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        if (mem_operation !== OP_IDLE) touched = 1'b1;
        if ((!who && rsp_done_a) || (who && rsp_done_b)) begin
          k = i;
          break;
        end
      end
      n_cmp++;
      if (k !== 0) begin
        n_bad++;
        $display("FAIL illegal_latency op=%0d: done at edge %0d, want 0", ops[t], k);
      end
      n_cmp++;
      if (touched !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal_mem_op op=%0d: memory operation issued, want none", ops[t]);
      end
      release_req(who);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    drive(1'b0, OP_READ, 4'd8, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (mem_operation !== OP_READ) begin
      n_bad++;
      $display("FAIL mid_issue_op: mem_operation=%0d, want %0d", mem_operation, OP_READ);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h, want 0", outs());
    end
    tb_last = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    // First tie after reset goes to A.
    push_exp(1'b0, OP_READ, 4'd8, '0);
    push_exp(1'b1, OP_READ, 4'd5, '0);
    @(negedge clk);
    req_a = 1'b1; op_a = OP_READ; addr_a = 4'd8;
    req_b = 1'b1; op_b = OP_READ; addr_b = 4'd5;
    wait_done(1'b0, 20, k);
    n_cmp++;
    if (k < 0 || k > 3) begin
      n_bad++;
      $display("FAIL post_reset_read: A done at edge %0d, want 0..3", k);
    end
    release_req(1'b0);
    wait_done(1'b1, 20, k);
    n_cmp++;
    if (k < 0) begin
      n_bad++;
      $display("FAIL post_reset_b: B done at edge %0d, want a completion", k);
    end
    release_req(1'b1);
  endtask

  task automatic test_timeout();
    int k;
    mem_hold = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    begin
      exp_t e;
      e.who = 1'b0; e.err = 1'b1; e.rdata = '0;
      tb_last = 1'b0;
      sb.push_back(e);
    end
    drive(1'b0, OP_WRITE, 4'd3, 16'h5555);
    wait_done(1'b0, 4 * TIMEOUT, k);
    n_cmp++;
    if (k !== TIMEOUT + 1) begin
      n_bad++;
      $display("FAIL timeout_latency: done at edge %0d, want %0d", k, TIMEOUT + 1);
    end
    release_req(1'b0);
    mem_hold = 1'b0;
    push_exp(1'b0, OP_READ, 4'd3, '0);
    drive(1'b0, OP_READ, 4'd3, '0);
    wait_done(1'b0, 20, k);
    release_req(1'b0);
`else
    drive(1'b0, OP_WRITE, 4'd3, 16'h5555);
    wait_done(1'b0, 3 * TIMEOUT, k);
    n_cmp++;
    if (k !== -1) begin
      n_bad++;
      $display("FAIL no_timeout_done: done at edge %0d, want none", k);
    end
    n_cmp++;
    if (mem_operation !== OP_WRITE) begin
      n_bad++;
      $display("FAIL no_timeout_hold: mem_operation=%0d, want %0d", mem_operation, OP_WRITE);
    end
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_hold = 1'b0;
    tb_last = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_clear_read();
    test_illegal();
    test_reset_mid();
    test_timeout();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL outstanding: %0d completions never arrived, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
